rf_operand_fetch: RTL and testbench
===================================

Name: rf_operand_fetch

Overview:
- Initiator/client for the single-port register file: sequences up to two operand reads and all writebacks through the file's one id/read/write port.
- Sits between decode and execute.
- Accepts an operand request, issues serialized reads, and presents both operands with a valid/ready handshake.
- Arbitrates writebacks (priority, with starvation guard) and keeps captured operands coherent with writes landing mid-request.

Parameters:
- REG_ID_LEN, 4: register index width; must match the register file.
- REG_SIZE, 64: register data width.
- STARVE_LIMIT, 4: consecutive read cycles a writeback may steal before wb_ready is dropped for one cycle; must be >= 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  operand request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_rs_a  in  REG_ID_LEN  source A index
- req_rs_b  in  REG_ID_LEN  source B index
- req_use_a  in  1  source A needed
- req_use_b  in  1  source B needed
- op_valid  out  1  operands available
- op_ready  in  1  consumer takes operands
- op_a  out  REG_SIZE  operand A (0 if unused)
- op_b  out  REG_SIZE  operand B (0 if unused)
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback accepted when wb_valid & wb_ready
- wb_rd  in  REG_ID_LEN  writeback index
- wb_value  in  REG_SIZE  writeback data
- rf_id  out  REG_ID_LEN  register file index
- rf_read  out  1  register file read strobe
- rf_write  out  1  register file write strobe
- rf_value  out  REG_SIZE  register file write data
- rf_out  in  REG_SIZE  register file read data; combinational, same cycle as rf_id

Behaviour:
- Reset (async, rst=1):
  - State IDLE; op_a, op_b, op_valid = 0.
  - Starve counter = 0.
  - rf_read, rf_write, rf_id, rf_value all forced to 0; no write reaches the file during reset.
  - Reset mid-request abandons the request; no op_valid follows.
- States: IDLE, RD_A, RD_B, HOLD.
- IDLE:
  - req_ready = 1.
  - On accept: latch rs_a, rs_b, use_a, use_b; clear op_a and op_b to 0.
  - Next state: RD_A if use_a, else RD_B if use_b, else HOLD.
- Port arbitration, every cycle:
  - wb_fire = wb_valid & wb_ready.
  - If wb_fire: rf_write = 1, rf_id = wb_rd, rf_value = wb_value, rf_read = 0.
  - Else in RD_A/RD_B: rf_read = 1, rf_id = latched rs_a or rs_b.
  - Otherwise: all rf_* outputs = 0.
- wb_ready:
  - 1, except in RD_A/RD_B when the starve counter == STARVE_LIMIT; then 0 for that cycle.
- RD_A:
  - No wb_fire: op_a <= rf_out; starve counter <= 0; next state RD_B if use_b, else HOLD.
  - wb_fire: stay in RD_A; starve counter += 1 (saturates at STARVE_LIMIT).
- RD_B: same as RD_A, capturing op_b; next state HOLD.
- HOLD:
  - op_valid = 1.
  - On op_ready: next state IDLE.
  - op_a/op_b held stable while op_valid=1 && !op_ready, except for forwarding (below).
- Forwarding/coherence:
  - On wb_fire with wb_rd == rs_a, when op_a is already captured (use_a, and state RD_B or HOLD): op_a <= wb_value.
  - Same for op_b in state HOLD.
  - rs_a == rs_b: both operands are updated.
  - A write in the same cycle as the read it blocks is picked up naturally by the retried read.
  - A writeback in the accept cycle commits before any read.
- Latency with no writebacks:
  - Both operands: accept at cycle 0, op_valid at cycle 3.
  - One operand: op_valid at cycle 2.
  - Neither operand: op_valid at cycle 1.
- Writebacks are never reordered. At most one write per cycle.

Decomposition:
- Shared package: state enum (IDLE, RD_A, RD_B, HOLD) and the REG_ID_LEN/REG_SIZE defaults shared with the register file.
- No sub-module needed. Optional sub-module rf_starve_guard, holding the counter and the wb_ready logic.

Test Plan:
- Preload r3=0x11, r7=0x22; request a=3, b=7, both used, op_ready=1 -> op_valid at cycle 3; op_a=0x11, op_b=0x22; rf_read high cycles 1-2, rf_id 3 then 7.
- Request with use_a=0, use_b=0 -> op_valid the cycle after accept; op_a=op_b=0; no rf_read.
- Hold wb_valid=1 continuously during RD_A, with STARVE_LIMIT=4 -> 4 writes pass; then wb_ready=0 for one cycle, the read of rs_a occurs, and writes resume.
- op_a captured from r5=0x10; in RD_B, a writeback r5=0x99 -> op_a=0x99 at op_valid; the register file also holds 0x99.
- In HOLD with op_ready=0 for 3 cycles, writeback r7=0x55 with rs_b=7 -> op_b becomes 0x55 and is stable thereafter; op_a unchanged.
- Assert rst during RD_B -> all outputs 0 immediately; after release state is IDLE, req_ready=1, no spurious op_valid.

Source files
------------

// File: rtl/rf_operand_fetch_pkg.sv
// Shared types and defaults for the operand-fetch client of the single-port register file.
// Widths must agree with the register file this block drives.
package rf_operand_fetch_pkg;

  localparam int unsigned REG_ID_LEN_DEF   = 4;
  localparam int unsigned REG_SIZE_DEF     = 64;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic is_read_state(input fetch_state_e s);
    return (s == ST_RD_A) || (s == ST_RD_B);
  endfunction

endpackage

// File: rtl/rf_operand_fetch_if.sv
// Bundle of the request, operand, writeback and register-file port signals.
// slave = the fetch unit itself, master = the surrounding pipeline and register file.
interface rf_operand_fetch_if #(
  parameter int unsigned REG_ID_LEN = rf_operand_fetch_pkg::REG_ID_LEN_DEF,
  parameter int unsigned REG_SIZE   = rf_operand_fetch_pkg::REG_SIZE_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic [REG_ID_LEN-1:0] req_rs_a;
  logic [REG_ID_LEN-1:0] req_rs_b;
  logic                  req_use_a;
  logic                  req_use_b;

  logic                  op_valid;
  logic                  op_ready;
  logic [REG_SIZE-1:0]   op_a;
  logic [REG_SIZE-1:0]   op_b;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ID_LEN-1:0] wb_rd;
  logic [REG_SIZE-1:0]   wb_value;

  logic [REG_ID_LEN-1:0] rf_id;
  logic                  rf_read;
  logic                  rf_write;
  logic [REG_SIZE-1:0]   rf_value;
  logic [REG_SIZE-1:0]   rf_out;

  modport slave (
    input  req_valid, req_rs_a, req_rs_b, req_use_a, req_use_b,
    output req_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  wb_valid, wb_rd, wb_value,
    output wb_ready,
    output rf_id, rf_read, rf_write, rf_value,
    input  rf_out
  );

  modport master (
    output req_valid, req_rs_a, req_rs_b, req_use_a, req_use_b,
    input  req_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output wb_valid, wb_rd, wb_value,
    input  wb_ready,
    input  rf_id, rf_read, rf_write, rf_value,
    output rf_out
  );

endinterface

// File: rtl/rf_operand_fetch_starve_guard.sv
// Counts consecutive read cycles stolen by writebacks and withholds wb_ready
// for one cycle once the limit is reached so the pending read can proceed.
module rf_starve_guard #(
  parameter int unsigned STARVE_LIMIT = rf_operand_fetch_pkg::STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_state_i,
  input  logic wb_fire_i,
  output logic wb_ready_o
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_limit;

  assign at_limit   = (cnt_q == LIMIT);
  assign wb_ready_o = !(rd_state_i && at_limit);

  // A read cycle without a writeback is the read completing, which clears the debt.
  always_comb begin
    cnt_d = cnt_q;
    if (rd_state_i) begin
      if (wb_fire_i) begin
        cnt_d = at_limit ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch unit: serializes up to two source reads and all writebacks through
// the register file's single port, forwarding writes into already captured operands.
module rf_operand_fetch
  import rf_operand_fetch_pkg::*;
#(
  parameter int unsigned REG_ID_LEN   = REG_ID_LEN_DEF,
  parameter int unsigned REG_SIZE     = REG_SIZE_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  rf_operand_fetch_if.slave  bus
);

  fetch_state_e          state_q, state_d;
  logic [REG_ID_LEN-1:0] rs_a_q, rs_a_d;
  logic [REG_ID_LEN-1:0] rs_b_q, rs_b_d;
  logic                  use_a_q, use_a_d;
  logic                  use_b_q, use_b_d;
  logic [REG_SIZE-1:0]   op_a_q, op_a_d;
  logic [REG_SIZE-1:0]   op_b_q, op_b_d;

  logic rd_state;
  logic guard_ready;
  logic wb_ready;
  logic wb_fire;
  logic fwd_a;
  logic fwd_b;

  assign rd_state = is_read_state(state_q);

  rf_starve_guard #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_guard (
    .clk        (clk),
    .rst        (rst),
    .rd_state_i (rd_state),
    .wb_fire_i  (wb_fire),
    .wb_ready_o (guard_ready)
  );

  // Handshakes are masked while reset is held so nothing reaches the file.
  assign wb_ready = guard_ready && !rst;
  assign wb_fire  = bus.wb_valid && wb_ready;

  assign bus.wb_ready  = wb_ready;
  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign bus.op_valid  = (state_q == ST_HOLD);
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;

  always_comb begin
    bus.rf_id    = '0;
    bus.rf_read  = 1'b0;
    bus.rf_write = 1'b0;
    bus.rf_value = '0;
    if (wb_fire) begin
      bus.rf_write = 1'b1;
      bus.rf_id    = bus.wb_rd;
      bus.rf_value = bus.wb_value;
    end else if (rd_state && !rst) begin
      bus.rf_read = 1'b1;
      bus.rf_id   = (state_q == ST_RD_A) ? rs_a_q : rs_b_q;
    end
  end

  // Forwarding applies only to operands that were already captured.
  assign fwd_a = wb_fire && use_a_q && (bus.wb_rd == rs_a_q) &&
                 ((state_q == ST_RD_B) || (state_q == ST_HOLD));
  assign fwd_b = wb_fire && use_b_q && (bus.wb_rd == rs_b_q) && (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    rs_a_d  = rs_a_q;
    rs_b_d  = rs_b_q;
    use_a_d = use_a_q;
    use_b_d = use_b_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;

    if (fwd_a) op_a_d = bus.wb_value;
    if (fwd_b) op_b_d = bus.wb_value;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          rs_a_d  = bus.req_rs_a;
          rs_b_d  = bus.req_rs_b;
          use_a_d = bus.req_use_a;
          use_b_d = bus.req_use_b;
          op_a_d  = '0;
          op_b_d  = '0;
          if (bus.req_use_a)      state_d = ST_RD_A;
          else if (bus.req_use_b) state_d = ST_RD_B;
          else                    state_d = ST_HOLD;
        end
      end
      ST_RD_A: begin
        if (!wb_fire) begin
          op_a_d  = bus.rf_out;
          state_d = use_b_q ? ST_RD_B : ST_HOLD;
        end
      end
      ST_RD_B: begin
        if (!wb_fire) begin
          op_b_d  = bus.rf_out;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.op_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rs_a_q  <= '0;
      rs_b_q  <= '0;
      use_a_q <= 1'b0;
      use_b_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      rs_a_q  <= rs_a_d;
      rs_b_q  <= rs_b_d;
      use_a_q <= use_a_d;
      use_b_q <= use_b_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch with a behavioural single-port register file.
module tb_rf_operand_fetch;

  localparam int unsigned IDW = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned SL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rf_operand_fetch_if #(.REG_ID_LEN(IDW), .REG_SIZE(DW)) bus ();

  rf_operand_fetch #(
    .REG_ID_LEN   (IDW),
    .REG_SIZE     (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rf_mem [1<<IDW];
  always @(posedge clk) if (bus.rf_write) rf_mem[bus.rf_id] <= bus.rf_value;
  assign bus.rf_out = rf_mem[bus.rf_id];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_pre(input logic [IDW-1:0] rd, input logic [DW-1:0] val);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_value = val;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic request(input logic [IDW-1:0] a, input logic [IDW-1:0] b,
                         input logic ua, input logic ub);
    bus.req_valid = 1'b1;
    bus.req_rs_a  = a;
    bus.req_rs_b  = b;
    bus.req_use_a = ua;
    bus.req_use_b = ub;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_rs_a  = '0;
    bus.req_rs_b  = '0;
    bus.req_use_a = 1'b0;
    bus.req_use_b = 1'b0;
    bus.op_ready  = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 4'd3;
    bus.wb_value  = 64'hDEAD;

    // Reset: outputs quiet, no write leaks through even with wb_valid high
    #2;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_rf_write", bus.rf_write, 0);
    chk("rst_wb_ready", bus.wb_ready, 0);
    chk("rst_rf_read", bus.rf_read, 0);
    tick();
    rst = 1'b0;
    bus.wb_valid = 1'b0;
    #2;
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk("post_rst_op_a", bus.op_a, 0);
    tick();

    wb_pre(4'd3, 64'h11);
    wb_pre(4'd7, 64'h22);
    wb_pre(4'd5, 64'h10);
    wb_pre(4'd6, 64'h66);
    wb_pre(4'd4, 64'h44);

    // Two operands, no writebacks: op_valid at cycle 3
    request(4'd3, 4'd7, 1'b1, 1'b1);
    #2 chk("t1_req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    #2;
    chk("t1_c1_rf_read", bus.rf_read, 1);
    chk("t1_c1_rf_id", bus.rf_id, 3);
    chk("t1_c1_op_valid", bus.op_valid, 0);
    tick();
    #2;
    chk("t1_c2_rf_read", bus.rf_read, 1);
    chk("t1_c2_rf_id", bus.rf_id, 7);
    tick();
    #2;
    chk("t1_c3_op_valid", bus.op_valid, 1);
    chk("t1_op_a", bus.op_a, 64'h11);
    chk("t1_op_b", bus.op_b, 64'h22);
    chk("t1_c3_rf_read", bus.rf_read, 0);
    chk("t1_c3_req_ready", bus.req_ready, 0);
    tick();
    #2;
    chk("t1_c4_op_valid", bus.op_valid, 0);
    chk("t1_c4_req_ready", bus.req_ready, 1);

    // No operands: op_valid the cycle after accept, operands cleared
    request(4'd3, 4'd7, 1'b0, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    #2;
    chk("t2_op_valid", bus.op_valid, 1);
    chk("t2_op_a", bus.op_a, 0);
    chk("t2_op_b", bus.op_b, 0);
    chk("t2_rf_read", bus.rf_read, 0);
    tick();
    #2 chk("t2_c2_op_valid", bus.op_valid, 0);

    // Starvation guard: four writes steal RD_A, then the read wins one cycle
    request(4'd4, 4'd0, 1'b1, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 4'd9;
    for (int i = 0; i < 4; i++) begin
      bus.wb_value = 64'hA0 + 64'(i);
      #2;
      chk($sformatf("t3_wb_ready_%0d", i), bus.wb_ready, 1);
      chk($sformatf("t3_rf_write_%0d", i), bus.rf_write, 1);
      chk($sformatf("t3_rf_read_%0d", i), bus.rf_read, 0);
      tick();
    end
    #2;
    chk("t3_starved_wb_ready", bus.wb_ready, 0);
    chk("t3_starved_rf_write", bus.rf_write, 0);
    chk("t3_starved_rf_read", bus.rf_read, 1);
    chk("t3_starved_rf_id", bus.rf_id, 4);
    tick();
    bus.wb_value = 64'hB0;
    #2;
    chk("t3_resume_wb_ready", bus.wb_ready, 1);
    chk("t3_resume_rf_write", bus.rf_write, 1);
    chk("t3_op_valid", bus.op_valid, 1);
    chk("t3_op_a", bus.op_a, 64'h44);
    chk("t3_op_b", bus.op_b, 0);
    tick();
    bus.wb_valid = 1'b0;
    #2 chk("t3_done_op_valid", bus.op_valid, 0);

    // Forward into captured op_a while RD_B is blocked by the writeback
    request(4'd5, 4'd6, 1'b1, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    #2 chk("t4_rd_a_id", bus.rf_id, 5);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd5;
    bus.wb_value = 64'h99;
    #2;
    chk("t4_wb_rf_write", bus.rf_write, 1);
    chk("t4_wb_rf_read", bus.rf_read, 0);
    tick();
    bus.wb_valid = 1'b0;
    #2;
    chk("t4_retry_rf_read", bus.rf_read, 1);
    chk("t4_retry_rf_id", bus.rf_id, 6);
    tick();
    #2;
    chk("t4_op_valid", bus.op_valid, 1);
    chk("t4_op_a_fwd", bus.op_a, 64'h99);
    chk("t4_op_b", bus.op_b, 64'h66);
    chk("t4_rf_r5", rf_mem[5], 64'h99);
    tick();

    // Forward into op_b while HOLD is stalled by op_ready=0
    bus.op_ready = 1'b0;
    request(4'd3, 4'd7, 1'b1, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    #2;
    chk("t5_hold_op_valid", bus.op_valid, 1);
    chk("t5_hold_op_b", bus.op_b, 64'h22);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd7;
    bus.wb_value = 64'h55;
    tick();
    bus.wb_valid = 1'b0;
    #2;
    chk("t5_op_b_fwd", bus.op_b, 64'h55);
    chk("t5_op_a_kept", bus.op_a, 64'h11);
    chk("t5_op_valid", bus.op_valid, 1);
    tick();
    #2;
    chk("t5_op_b_stable", bus.op_b, 64'h55);
    chk("t5_op_valid2", bus.op_valid, 1);
    bus.op_ready = 1'b1;
    tick();
    #2 chk("t5_released", bus.op_valid, 0);

    // rs_a == rs_b: a write to that register updates both operands
    bus.op_ready = 1'b0;
    request(4'd7, 4'd7, 1'b1, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    #2 chk("t6_op_a_before", bus.op_a, 64'h55);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd7;
    bus.wb_value = 64'h77;
    tick();
    bus.wb_valid = 1'b0;
    #2;
    chk("t6_op_a_fwd", bus.op_a, 64'h77);
    chk("t6_op_b_fwd", bus.op_b, 64'h77);
    bus.op_ready = 1'b1;
    tick();

    // Writeback in the accept cycle commits before the read
    request(4'd3, 4'd0, 1'b1, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd3;
    bus.wb_value = 64'hAB;
    tick();
    bus.req_valid = 1'b0;
    bus.wb_valid  = 1'b0;
    tick();
    #2;
    chk("t7_op_valid", bus.op_valid, 1);
    chk("t7_op_a", bus.op_a, 64'hAB);
    tick();

    // Reset asserted mid RD_B abandons the request
    request(4'd3, 4'd7, 1'b1, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd2;
    bus.wb_value = 64'hEE;
    #1;
    rst = 1'b1;
    #1;
    chk("t8_rf_read", bus.rf_read, 0);
    chk("t8_rf_write", bus.rf_write, 0);
    chk("t8_rf_id", bus.rf_id, 0);
    chk("t8_rf_value", bus.rf_value, 0);
    chk("t8_wb_ready", bus.wb_ready, 0);
    chk("t8_req_ready", bus.req_ready, 0);
    chk("t8_op_a", bus.op_a, 0);
    bus.wb_valid = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    chk("t8_rel_req_ready", bus.req_ready, 1);
    chk("t8_rel_op_valid", bus.op_valid, 0);
    chk("t8_rel_rf_read", bus.rf_read, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk($sformatf("t8_idle_op_valid_%0d", i), bus.op_valid, 0);
      chk($sformatf("t8_idle_rf_read_%0d", i), bus.rf_read, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
